// File: rtl/trng_pkg.sv
// Shared types and helpers for the TRNG bit source.
package trng_pkg;

  // Von Neumann pairing state: waiting for first sample, or holding it.
  typedef enum logic [0:0] {
    VN_IDLE  = 1'b0,
    VN_HAVE1 = 1'b1
  } vn_state_e;

  // Width of a counter that must be able to hold the value 0..cutoff.
  function automatic int unsigned rct_cnt_width(input int unsigned cutoff);
    return $clog2(cutoff + 1);
  endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser plus repetition-count health test on the raw noise stream.
module trng_vn_debias
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = 31,
  parameter bit          VN_ENABLE  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_bit,
  input  logic raw_valid,
  input  logic flush,
  input  logic clr,
  output logic vn_bit,
  output logic vn_valid,
  output logic fail_pulse
);

  localparam int unsigned     CntW   = rct_cnt_width(RCT_CUTOFF);
  localparam logic [CntW-1:0] Cutoff = CntW'(RCT_CUTOFF);

  vn_state_e       state_q, state_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d, rct_next;

  // State register for the pairing FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= VN_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Pairing FSM next state; a flush abandons any half-formed pair.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    if (raw_valid) begin
      case (state_q)
        VN_IDLE: begin
          state_d = VN_HAVE1;
          first_d = raw_bit;
        end
        VN_HAVE1: state_d = VN_IDLE;
        default:  state_d = VN_IDLE;
      endcase
    end
    if (flush) begin
      state_d = VN_IDLE;
    end
  end

  // Emit on a completed unequal pair: 01 -> 0, 10 -> 1, i.e. the first sample.
  always_comb begin
    vn_bit   = 1'b0;
    vn_valid = 1'b0;
    if (VN_ENABLE) begin
      if (raw_valid && (state_q == VN_HAVE1) && (first_q != raw_bit)) begin
        vn_valid = 1'b1;
        vn_bit   = first_q;
      end
    end else begin
      vn_valid = raw_valid;
      vn_bit   = raw_bit;
    end
  end

  // Repetition count: a zero count means no previous sample to compare against.
  always_comb begin
    rct_next = cnt_q;
    last_d   = last_q;
    if (raw_valid) begin
      if ((cnt_q != '0) && (raw_bit == last_q)) begin
        rct_next = (cnt_q == Cutoff) ? cnt_q : cnt_q + 1'b1;
      end else begin
        rct_next = CntW'(1);
        last_d   = raw_bit;
      end
    end
    // Fire only on the transition into the cutoff, not while saturated there.
    fail_pulse = raw_valid && (rct_next == Cutoff) && (cnt_q != Cutoff);
    cnt_d      = clr ? (raw_valid ? CntW'(1) : '0) : rct_next;
  end

  // Health-test counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/trng_bit_source.sv
// TRNG source: conditions noise, buffers conditioned bits, shifts one out per request.
module trng_bit_source
  import trng_pkg::*;
#(
  parameter int unsigned BUF_BITS   = 32,
  parameter int unsigned RCT_CUTOFF = 31,
  parameter bit          VN_ENABLE  = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            raw_bit,
  input  logic                            raw_valid,
  input  logic                            trng_req,
  output logic                            trng_bit,
  output logic [$clog2(BUF_BITS+1)-1:0]   buf_level,
  output logic                            underrun,
  output logic                            health_fail,
  input  logic                            clr_flags
);

  localparam int unsigned     LvlW = $clog2(BUF_BITS + 1);
  localparam logic [LvlW-1:0] Full = LvlW'(BUF_BITS);

  // Bit 0 is the head; unused slots are kept at zero so the head reads 0 when empty.
  logic [BUF_BITS-1:0] fifo_q, fifo_d;
  logic [LvlW-1:0]     level_q, level_d, wr_idx;
  logic                underrun_q, underrun_d;
  logic                health_fail_q, health_fail_d;
  logic                vn_bit, vn_valid, fail_pulse;
  logic                pop, push;

  trng_vn_debias #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .VN_ENABLE  (VN_ENABLE)
  ) u_debias (
    .clk        (clk),
    .reset      (reset),
    .raw_bit    (raw_bit),
    .raw_valid  (raw_valid),
    .flush      (fail_pulse),
    .clr        (clr_flags),
    .vn_bit     (vn_bit),
    .vn_valid   (vn_valid),
    .fail_pulse (fail_pulse)
  );

  // FIFO next state: shift on pop, write behind the surviving bits, flush on health failure.
  always_comb begin
    pop    = trng_req && (level_q != '0);
    push   = vn_valid && !health_fail_q && !fail_pulse && ((level_q != Full) || pop);
    wr_idx = level_q - LvlW'(pop);
    fifo_d = pop ? (fifo_q >> 1) : fifo_q;
    for (int i = 0; i < BUF_BITS; i++) begin
      if (push && (wr_idx == LvlW'(i))) begin
        fifo_d[i] = vn_bit;
      end
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (fail_pulse) begin
      fifo_d  = '0;
      level_d = '0;
    end
  end

  // Sticky flags; a set event in the same cycle as a clear wins.
  always_comb begin
    underrun_d    = (underrun_q && !clr_flags) || (trng_req && (level_q == '0));
    health_fail_d = (health_fail_q && !clr_flags) || fail_pulse;
  end

  // Buffer and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q        <= '0;
      level_q       <= '0;
      underrun_q    <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      level_q       <= level_d;
      underrun_q    <= underrun_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign trng_bit    = fifo_q[0];
  assign buf_level   = level_q;
  assign underrun    = underrun_q;
  assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_bit_source.sv
// Scoreboard bench for trng_bit_source against a queue-based reference model.
module tb_trng_bit_source;

  localparam int unsigned B  = 32;
  localparam int unsigned C  = 31;
  localparam int unsigned LW = $clog2(B + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          raw_bit;
  logic          raw_valid;
  logic          trng_req;
  logic          clr_flags;
  logic          trng_bit;
  logic [LW-1:0] buf_level;
  logic          underrun;
  logic          health_fail;

  trng_bit_source #(
    .BUF_BITS   (B),
    .RCT_CUTOFF (C),
    .VN_ENABLE  (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .trng_req    (trng_req),
    .trng_bit    (trng_bit),
    .buf_level   (buf_level),
    .underrun    (underrun),
    .health_fail (health_fail),
    .clr_flags   (clr_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    int   lvl;
    logic und;
    logic hf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t new_e;

  // Reference model state: buffered bits, flags, pairing and run-length bookkeeping.
  bit m_q[$];
  bit m_und, m_hf, m_have, m_first, m_last;
  int m_cnt;

  int checks   = 0;
  int failures = 0;

  bit r_rst, r_rb, r_rv, r_req, r_clr;
  logic [31:0] pat;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit rb, input bit rv, input bit req,
                            input bit clr);
    bit emit;
    bit ebit;
    bit fail;
    int pre;
    if (rst) begin
      m_q.delete();
      m_und   = 1'b0;
      m_hf    = 1'b0;
      m_have  = 1'b0;
      m_first = 1'b0;
      m_last  = 1'b0;
      m_cnt   = 0;
      return;
    end
    emit = 1'b0;
    ebit = 1'b0;
    fail = 1'b0;
    if (rv) begin
      if (m_cnt > 0 && rb == m_last) begin
        if (m_cnt < C) begin
          m_cnt++;
          if (m_cnt == C) fail = 1'b1;
        end
      end else begin
        m_cnt  = 1;
        m_last = rb;
      end
      if (!m_have) begin
        m_have  = 1'b1;
        m_first = rb;
      end else begin
        m_have = 1'b0;
        if (m_first != rb) begin
          emit = 1'b1;
          ebit = m_first;
        end
      end
    end
    pre = m_q.size();
    if (req && pre > 0) void'(m_q.pop_front());
    if (emit && !m_hf && !fail && (pre < B || (req && pre > 0))) m_q.push_back(ebit);
    if (fail) begin
      m_q.delete();
      m_have = 1'b0;
    end
    if (clr) m_cnt = rv ? 1 : 0;
    m_und = (m_und && !clr) || (req && pre == 0);
    m_hf  = (m_hf && !clr) || fail;
  endtask

  // One clock of stimulus; the expectation is queued once the edge has happened.
  task automatic cyc(input bit rst, input bit rb, input bit rv, input bit req, input bit clr);
    reset     = rst;
    raw_bit   = rb;
    raw_valid = rv;
    trng_req  = req;
    clr_flags = clr;
    model_step(rst, rb, rv, req, clr);
    @(posedge clk);
    #1;
    new_e.b   = (m_q.size() > 0) ? m_q[0] : 1'b0;
    new_e.lvl = m_q.size();
    new_e.und = m_und;
    new_e.hf  = m_hf;
    exp_q.push_back(new_e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear_flags();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // A (b, !b) raw pair conditions to exactly b; req optionally high on the completing sample.
  task automatic push_bit(input bit b, input bit req_on_second);
    cyc(1'b0, b, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, !b, 1'b1, req_on_second, 1'b0);
  endtask

  // Monitor: every DUT output is flop-driven, so compare once per cycle away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("trng_bit", int'(trng_bit), int'(mon_e.b));
      chk("buf_level", int'(buf_level), mon_e.lvl);
      chk("underrun", int'(underrun), int'(mon_e.und));
      chk("health_fail", int'(health_fail), int'(mon_e.hf));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    raw_bit   = 1'b0;
    raw_valid = 1'b0;
    trng_req  = 1'b0;
    clr_flags = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Raw 0,1,1,0,0,0,1,1: two unequal pairs emit 0 then 1.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain(3);                   // third request underruns
    idle(1);
    clear_flags();
    idle(1);

    // Fill with 0xA5A5A5A5 then drain 32.
    pat = 32'hA5A5_A5A5;
    for (int i = 31; i >= 0; i--) push_bit(pat[i], 1'b0);
    drain(32);
    idle(1);

    // Underrun on empty, then clear.
    drain(1);
    idle(1);
    clear_flags();

    // Health failure: some bits buffered, then 31 consecutive 1s.
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b0);
    for (int i = 0; i < 31; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_bit(1'b0, 1'b0);       // blocked while health_fail
    push_bit(1'b1, 1'b0);
    clear_flags();
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    drain(3);
    clear_flags();

    // Full buffer: push+pop at the same edge keeps level, push-only is dropped.
    pat = 32'h3C5A_0FF1;
    for (int i = 31; i >= 0; i--) push_bit(pat[i], 1'b0);
    push_bit(1'b1, 1'b1);
    push_bit(1'b0, 1'b0);
    drain(33);
    clear_flags();

    // Reset mid-drain.
    for (int i = 0; i < 10; i++) push_bit(i[0], 1'b0);
    drain(3);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(1);
    clear_flags();

    // Randomized traffic: fair and heavily biased noise, light and heavy readers.
    for (int p = 0; p < 6; p++) begin
      for (int n = 0; n < 500; n++) begin
        r_rv  = ($urandom_range(0, 3) != 0);
        r_rb  = (p % 2 == 1) ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 1) == 1);
        r_req = ($urandom_range(0, 7) < ((p < 3) ? 2 : 5));
        r_clr = !r_rv && ($urandom_range(0, 63) == 0);
        r_rst = ($urandom_range(0, 999) == 0);
        cyc(r_rst, r_rb, r_rv, r_req, r_clr);
      end
    end

    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
